if_id_buf: RTL and testbench

IF_ID_BUF -- requirements
Module: if_id_buf

---
 rtl/if_id_buf.sv | 102 ++++++++++
 tb/tb_if_id_buf.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: small circular FIFO between fetch and decode.
// Carries the fetch exception tag with each entry; flush and reset empty it.
module if_id_buf #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] inst_sram_rdata,
    input  logic        in_has_exception,
    input  logic [5:0]  in_ecode,
    input  logic [8:0]  in_esubcode,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_has_exception,
    output logic [5:0]  out_ecode,
    output logic [8:0]  out_esubcode
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        has_exception;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    entry_t          wr_entry;
    entry_t          head;

    assign in_ready  = !rst && !flush && (count < FULL);
    assign out_valid = (count != '0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A faulting fetch has no meaningful instruction word, so store a zero.
    always_comb begin
        wr_entry               = '0;
        wr_entry.pc            = in_pc;
        wr_entry.inst          = in_has_exception ? '0 : inst_sram_rdata;
        wr_entry.has_exception = in_has_exception;
        wr_entry.ecode         = in_ecode;
        wr_entry.esubcode      = in_esubcode;
    end

    always_comb begin
        head = '0;
        if (!rst) begin
            head = mem[rd_ptr];
        end
    end

    assign out_pc            = head.pc;
    assign out_inst          = head.inst;
    assign out_has_exception = head.has_exception;
    assign out_ecode         = head.ecode;
    assign out_esubcode      = head.esubcode;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: directed vector table, then random traffic checked
// against a queue-based reference model.
module tb_if_id_buf;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_has_exception, flush, out_valid, out_ready;
    logic [31:0] in_pc, inst_sram_rdata, out_pc, out_inst;
    logic [5:0]  in_ecode, out_ecode;
    logic [8:0]  in_esubcode, out_esubcode;
    logic        out_has_exception;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_id_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .inst_sram_rdata(inst_sram_rdata), .in_has_exception(in_has_exception),
        .in_ecode(in_ecode), .in_esubcode(in_esubcode), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_has_exception(out_has_exception),
        .out_ecode(out_ecode), .out_esubcode(out_esubcode)
    );

    typedef struct {
        logic rst, iv; logic [31:0] pc, rd; logic exc, fl, ordy;
        logic e_ir, e_ov, c_ov, c_d; logic [31:0] e_pc, e_inst; logic e_exc;
    } vec_t;

    typedef struct {
        logic [31:0] pc, inst; logic exc; logic [5:0] ec; logic [8:0] es;
    } ent_t;

    function automatic vec_t v(input logic r, iv, input logic [31:0] pc, rd,
                               input logic exc, fl, ordy, ir, ov, cov, cd,
                               input logic [31:0] epc, einst, input logic eexc);
        vec_t t;
        t = '{r, iv, pc, rd, exc, fl, ordy, ir, ov, cov, cd, epc, einst, eexc};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, iv, input logic [31:0] pc, rd, input logic exc,
                         input logic [5:0] ec, input logic [8:0] es, input logic fl, ordy);
        rst = r; in_valid = iv; in_pc = pc; inst_sram_rdata = rd;
        in_has_exception = exc; in_ecode = ec; in_esubcode = es;
        flush = fl; out_ready = ordy;
    endtask

    vec_t tbl[20];
    ent_t q[$];

    initial begin
        tbl[0]  = v(1, 1, 32'h1c00aaaa, 32'h0,        0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0);
        tbl[1]  = v(0, 1, 32'h1c000000, 32'h02800421, 0, 0, 0, 1, 0, 1, 0, 32'h0,        32'h0,        0);
        tbl[2]  = v(0, 1, 32'h1c000004, 32'h02800842, 0, 0, 0, 1, 1, 1, 1, 32'h1c000000, 32'h02800421, 0);
        tbl[3]  = v(0, 1, 32'h1c000008, 32'h02800c63, 0, 0, 0, 0, 1, 1, 1, 32'h1c000000, 32'h02800421, 0);
        tbl[4]  = v(0, 1, 32'h1c000008, 32'h02800c63, 0, 0, 1, 0, 1, 1, 1, 32'h1c000000, 32'h02800421, 0);
        tbl[5]  = v(0, 1, 32'h1c000008, 32'h02800c63, 0, 0, 1, 1, 1, 1, 1, 32'h1c000004, 32'h02800842, 0);
        tbl[6]  = v(0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 1, 1, 1, 32'h1c000008, 32'h02800c63, 0);
        tbl[7]  = v(0, 1, 32'h1c00000c, 32'hdeadbeef, 1, 0, 1, 1, 1, 1, 1, 32'h1c000008, 32'h02800c63, 0);
        tbl[8]  = v(0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 1, 1, 1, 32'h1c00000c, 32'h0,        1);
        tbl[9]  = v(0, 1, 32'h1c000010, 32'h02801084, 0, 0, 0, 1, 1, 1, 1, 32'h1c00000c, 32'h0,        1);
        tbl[10] = v(0, 1, 32'h1c000014, 32'h02801485, 0, 1, 1, 0, 0, 1, 0, 32'h0,        32'h0,        0);
        tbl[11] = v(0, 1, 32'h1c000018, 32'h02801886, 0, 1, 1, 0, 0, 1, 0, 32'h0,        32'h0,        0);
        tbl[12] = v(0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 0, 1, 0, 32'h0,        32'h0,        0);
        tbl[13] = v(0, 1, 32'h1c000020, 32'h11111111, 0, 0, 0, 1, 0, 1, 0, 32'h0,        32'h0,        0);
        tbl[14] = v(0, 1, 32'h1c000024, 32'h22222222, 0, 0, 0, 1, 1, 1, 1, 32'h1c000020, 32'h11111111, 0);
        tbl[15] = v(1, 1, 32'h1c000028, 32'h33333333, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0);
        tbl[16] = v(0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 0, 1, 1, 32'h0,        32'h0,        0);
        tbl[17] = v(0, 1, 32'h1c000030, 32'h33333333, 0, 0, 0, 1, 0, 1, 0, 32'h0,        32'h0,        0);
        tbl[18] = v(0, 0, 32'h0,        32'h0,        0, 0, 1, 1, 1, 1, 1, 32'h1c000030, 32'h33333333, 0);
        tbl[19] = v(0, 0, 32'h0,        32'h0,        0, 0, 1, 1, 0, 1, 0, 32'h0,        32'h0,        0);

        drive(1, 0, '0, '0, 0, '0, '0, 0, 0);
        repeat (2) @(posedge clk);

        // Directed table: each row's expectations hold in the cycle its inputs are applied.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].iv, tbl[i].pc, tbl[i].rd, tbl[i].exc,
                  tbl[i].exc ? 6'h08 : 6'h00, 9'h0, tbl[i].fl, tbl[i].ordy);
            #1;
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            if (tbl[i].c_ov) chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].c_d) begin
                chk($sformatf("row%0d out_pc", i), out_pc, tbl[i].e_pc);
                chk($sformatf("row%0d out_inst", i), out_inst, tbl[i].e_inst);
                chk($sformatf("row%0d out_exc", i), 32'(out_has_exception), 32'(tbl[i].e_exc));
                chk($sformatf("row%0d out_ecode", i), 32'(out_ecode), tbl[i].e_exc ? 32'h8 : 32'h0);
                chk($sformatf("row%0d out_esub", i), 32'(out_esubcode), 32'h0);
            end
            @(posedge clk);
        end

        // Random traffic against a queue model; begin from a known reset.
        @(negedge clk);
        drive(1, 0, '0, '0, 0, '0, '0, 0, 0);
        @(posedge clk);
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic r, iv, exc, fl, ordy, e_ir, e_ov;
            logic [31:0] pc, rd;
            logic [5:0] ec;
            logic [8:0] es;
            ent_t e;
            @(negedge clk);
            r    = ($urandom_range(63) == 0);
            fl   = ($urandom_range(15) == 0);
            iv   = ($urandom_range(9) < 7);
            ordy = ($urandom_range(1) == 1);
            exc  = ($urandom_range(7) == 0);
            pc   = $urandom; rd = $urandom;
            ec   = 6'($urandom); es = 9'($urandom);
            drive(r, iv, pc, rd, exc, ec, es, fl, ordy);
            e_ir = !r && !fl && (q.size() < DEPTH);
            e_ov = (q.size() != 0) && !fl;
            #1;
            chk("rnd in_ready", 32'(in_ready), 32'(e_ir));
            if (r) begin
                chk("rnd rst out_pc", out_pc, 32'h0);
                chk("rnd rst out_inst", out_inst, 32'h0);
                chk("rnd rst out_tag", {14'h0, out_has_exception, out_ecode, out_esubcode}, 32'h0);
            end else begin
                chk("rnd out_valid", 32'(out_valid), 32'(e_ov));
                if (e_ov) begin
                    chk("rnd out_pc", out_pc, q[0].pc);
                    chk("rnd out_inst", out_inst, q[0].inst);
                    chk("rnd out_exc", 32'(out_has_exception), 32'(q[0].exc));
                    chk("rnd out_ecode", 32'(out_ecode), 32'(q[0].ec));
                    chk("rnd out_esub", 32'(out_esubcode), 32'(q[0].es));
                end
            end
            @(posedge clk);
            if (r || fl) begin
                q.delete();
            end else begin
                if (e_ov && ordy) void'(q.pop_front());
                if (iv && e_ir) begin
                    e = '{pc, exc ? 32'h0 : rd, exc, ec, es};
                    q.push_back(e);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
